time_set_ctrl: RTL and testbench

//  Time-setting controller for the 24 h digital clock. Sits between the debounced keys and the

---
 rtl/time_set_if.sv | 24 ++
 rtl/time_set_ctrl.sv | 157 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/time_set_if.sv
// Key inputs, live time and controller outputs bundled for the time-setting controller.
interface time_set_if;
    logic        key_mode;
    logic        key_inc;
    logic        key_dec;
    logic [16:0] cur_time;
    logic        run_en;
    logic        set_load;
    logic [16:0] set_time;
    logic [16:0] disp_time;
    logic [5:0]  blink_mask;

    // Drives keys and live time, observes controller outputs.
    modport master (
        output key_mode, key_inc, key_dec, cur_time,
        input  run_en, set_load, set_time, disp_time, blink_mask
    );

    // The controller itself.
    modport slave (
        input  key_mode, key_inc, key_dec, cur_time,
        output run_en, set_load, set_time, disp_time, blink_mask
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting controller for a 24 h clock: freezes the counter, edits hh/mm/ss
// in shadow registers, loads the result back and drives display/blink outputs.
// Time format: {hour[16:12], min[11:6], sec[5:0]}.
module time_set_ctrl #(
    parameter int BLINK_HALF  = 25_000_000,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input logic        clk,
    input logic        rst,
    time_set_if.slave  bus
);
    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;

    localparam int BW = $clog2(BLINK_HALF);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);

    state_t        state_reg, state_next;
    logic [4:0]    hh_reg, hh_next;
    logic [5:0]    mm_reg, mm_next;
    logic [5:0]    ss_reg, ss_next;
    logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
    logic          phase_reg, phase_next;
    logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic          run_en_reg, run_en_next;
    logic          set_load_reg, set_load_next;
    logic [16:0]   set_time_reg, set_time_next;
    logic [16:0]   disp_time_reg, disp_time_next;
    logic [5:0]    blink_mask_reg, blink_mask_next;
    logic [2:0]    field_sel;

    logic in_set, inc_ok, dec_ok, edit, timeout_hit;

    // A lone inc or dec is an edit; key_mode wins and inc+dec together cancel out.
    assign in_set      = (state_reg != RUN);
    assign inc_ok      = in_set && bus.key_inc && !bus.key_dec && !bus.key_mode;
    assign dec_ok      = in_set && bus.key_dec && !bus.key_inc && !bus.key_mode;
    assign edit        = inc_ok || dec_ok;
    assign timeout_hit = in_set && !bus.key_mode && !edit && (tmo_cnt_reg == TMO_LAST);

    // Next-state, shadow edits, counters and next output values.
    always_comb begin
        state_next     = state_reg;
        hh_next        = hh_reg;
        mm_next        = mm_reg;
        ss_next        = ss_reg;
        set_load_next  = 1'b0;
        set_time_next  = set_time_reg;
        blink_cnt_next = blink_cnt_reg;
        phase_next     = phase_reg;
        tmo_cnt_next   = tmo_cnt_reg;

        case (state_reg)
            RUN: begin
                if (bus.key_mode) begin
                    state_next = SET_HOUR;
                    hh_next    = bus.cur_time[16:12];
                    mm_next    = bus.cur_time[11:6];
                    ss_next    = bus.cur_time[5:0];
                end
            end
            SET_HOUR: begin
                if (bus.key_mode)   state_next = SET_MIN;
                else if (timeout_hit) state_next = RUN;
                else if (inc_ok)    hh_next = (hh_reg == 5'd23) ? 5'd0 : hh_reg + 5'd1;
                else if (dec_ok)    hh_next = (hh_reg == 5'd0) ? 5'd23 : hh_reg - 5'd1;
            end
            SET_MIN: begin
                if (bus.key_mode)   state_next = SET_SEC;
                else if (timeout_hit) state_next = RUN;
                else if (inc_ok)    mm_next = (mm_reg == 6'd59) ? 6'd0 : mm_reg + 6'd1;
                else if (dec_ok)    mm_next = (mm_reg == 6'd0) ? 6'd59 : mm_reg - 6'd1;
            end
            SET_SEC: begin
                if (bus.key_mode) begin
                    state_next    = RUN;
                    set_load_next = 1'b1;
                    set_time_next = {hh_reg, mm_reg, ss_reg};
                end
                else if (timeout_hit) state_next = RUN;
                else if (inc_ok)    ss_next = (ss_reg == 6'd59) ? 6'd0 : ss_reg + 6'd1;
                else if (dec_ok)    ss_next = (ss_reg == 6'd0) ? 6'd59 : ss_reg - 6'd1;
            end
            default: state_next = RUN;
        endcase

        // Idle timer restarts on any accepted key and only runs while editing.
        if (bus.key_mode || edit || state_next == RUN)
            tmo_cnt_next = '0;
        else
            tmo_cnt_next = tmo_cnt_reg + 1'b1;

        // Blink restarts visible on every state change or edit.
        if (state_next == RUN || state_next != state_reg || edit) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end
        else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
        end
        else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
        end
    end

    assign run_en_next    = (state_next == RUN);
    assign disp_time_next = (state_next == RUN) ? bus.cur_time : {hh_next, mm_next, ss_next};

    // Field select index: 2 = hour, 1 = minute, 0 = second.
    assign field_sel = {state_next == SET_HOUR, state_next == SET_MIN, state_next == SET_SEC};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_mask
            assign blink_mask_next[2*gi +: 2] = {2{phase_next & field_sel[gi]}};
        end
    endgenerate

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= RUN;
            hh_reg         <= '0;
            mm_reg         <= '0;
            ss_reg         <= '0;
            blink_cnt_reg  <= '0;
            phase_reg      <= 1'b0;
            tmo_cnt_reg    <= '0;
            run_en_reg     <= 1'b1;
            set_load_reg   <= 1'b0;
            set_time_reg   <= '0;
            disp_time_reg  <= '0;
            blink_mask_reg <= '0;
        end
        else begin
            state_reg      <= state_next;
            hh_reg         <= hh_next;
            mm_reg         <= mm_next;
            ss_reg         <= ss_next;
            blink_cnt_reg  <= blink_cnt_next;
            phase_reg      <= phase_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            run_en_reg     <= run_en_next;
            set_load_reg   <= set_load_next;
            set_time_reg   <= set_time_next;
            disp_time_reg  <= disp_time_next;
            blink_mask_reg <= blink_mask_next;
        end
    end

    assign bus.run_en     = run_en_reg;
    assign bus.set_load   = set_load_reg;
    assign bus.set_time   = set_time_reg;
    assign bus.disp_time  = disp_time_reg;
    assign bus.blink_mask = blink_mask_reg;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: directed key sequences, load scoreboard with a monitor.
module tb_time_set_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    time_set_if bus();

    time_set_ctrl #(.BLINK_HALF(4), .TIMEOUT_CYC(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;
    logic [16:0] exp_q[$];

    function automatic logic [16:0] tp(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive a one-cycle key pulse; call just after a rising edge.
    task automatic press(input logic m, input logic i, input logic d);
        bus.key_mode = m;
        bus.key_inc  = i;
        bus.key_dec  = d;
        @(posedge clk);
        #1;
        bus.key_mode = 1'b0;
        bus.key_inc  = 1'b0;
        bus.key_dec  = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every set_load pulse is matched against the expected-load queue.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (bus.set_load === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_load: set_time %h, no load expected", bus.set_time);
                end
                else begin
                    e = exp_q.pop_front();
                    $display("load: set_time=%h expected=%h", bus.set_time, e);
                    check("set_time", 32'(bus.set_time), 32'(e));
                    check("run_en_at_load", 32'(bus.run_en), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.key_mode = 1'b0;
        bus.key_inc  = 1'b0;
        bus.key_dec  = 1'b0;
        bus.cur_time = '0;

        // 1: reset state and RUN display tracking with one-cycle lag
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_run_en", 32'(bus.run_en), 32'd1);
        check("rst_set_load", 32'(bus.set_load), 32'd0);
        check("rst_blink", 32'(bus.blink_mask), 32'd0);
        check("rst_disp", 32'(bus.disp_time), 32'd0);
        sync();
        rst = 1'b0;
        bus.cur_time = tp(1, 2, 3);
        @(negedge clk);
        check("disp_lag_old", 32'(bus.disp_time), 32'd0);
        @(negedge clk);
        check("disp_lag_new", 32'(bus.disp_time), 32'(tp(1, 2, 3)));
        $display("txn: reset and display tracking");

        // 2: full edit 12:34:56 -> 15:04:01
        sync();
        bus.cur_time = tp(12, 34, 56);
        sync();
        press(1, 0, 0);
        bus.cur_time = tp(0, 0, 1);
        repeat (3) press(0, 1, 0);
        @(negedge clk);
        check("edit_hour_disp", 32'(bus.disp_time), 32'(tp(15, 34, 56)));
        check("edit_run_en", 32'(bus.run_en), 32'd0);
        check("edit_blink_hour", 32'(bus.blink_mask), 32'd0);
        sync();
        press(1, 0, 0);
        repeat (30) press(0, 0, 1);
        press(1, 0, 0);
        repeat (5) press(0, 1, 0);
        @(negedge clk);
        check("edit_all_disp", 32'(bus.disp_time), 32'(tp(15, 4, 1)));
        sync();
        exp_q.push_back(tp(15, 4, 1));
        press(1, 0, 0);
        @(negedge clk);
        check("after_load_run_en", 32'(bus.run_en), 32'd1);
        check("after_load_disp", 32'(bus.disp_time), 32'(tp(0, 0, 1)));
        $display("txn: edit 12:34:56 -> 15:04:01");

        // 3: wrap without carry
        sync();
        bus.cur_time = tp(23, 59, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        @(negedge clk);
        check("wrap_hour", 32'(bus.disp_time), 32'(tp(0, 59, 0)));
        sync();
        press(1, 0, 0);
        press(0, 1, 0);
        @(negedge clk);
        check("wrap_min", 32'(bus.disp_time), 32'(tp(0, 0, 0)));
        sync();
        press(1, 0, 0);
        press(0, 0, 1);
        @(negedge clk);
        check("wrap_sec_dec", 32'(bus.disp_time), 32'(tp(0, 0, 59)));
        sync();
        exp_q.push_back(tp(0, 0, 59));
        press(1, 0, 0);
        $display("txn: field wrap");

        // 4: blink in SET_MIN and timeout abort
        bus.cur_time = tp(1, 2, 3);
        press(1, 0, 0);
        press(1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("blink_%0d", i), 32'(bus.blink_mask),
                  ((i / 4) % 2 == 1) ? 32'h0c : 32'h00);
            if (i == 19) check("pre_timeout_run_en", 32'(bus.run_en), 32'd0);
        end
        @(negedge clk);
        check("timeout_run_en", 32'(bus.run_en), 32'd1);
        check("timeout_blink", 32'(bus.blink_mask), 32'd0);
        check("timeout_disp", 32'(bus.disp_time), 32'(tp(1, 2, 3)));
        $display("txn: blink and timeout");

        // 5: hour dec wrap, key priority, inc+dec ignored (timeout not cleared)
        sync();
        bus.cur_time = tp(0, 6, 7);
        press(1, 0, 0);
        press(0, 0, 1);
        @(negedge clk);
        check("wrap_hour_dec", 32'(bus.disp_time), 32'(tp(23, 6, 7)));
        sync();
        press(1, 1, 0);
        press(0, 1, 1);
        @(negedge clk);
        check("prio_fields", 32'(bus.disp_time), 32'(tp(23, 6, 7)));
        repeat (17) @(negedge clk);
        @(negedge clk);
        check("incdec_pre_timeout", 32'(bus.run_en), 32'd0);
        @(negedge clk);
        check("incdec_timeout", 32'(bus.run_en), 32'd1);
        $display("txn: priority and inc+dec");

        // 6: reset mid-edit discards the edit
        sync();
        bus.cur_time = tp(10, 20, 30);
        repeat (3) press(1, 0, 0);
        press(0, 1, 0);
        @(negedge clk);
        check("pre_rst_disp", 32'(bus.disp_time), 32'(tp(10, 20, 31)));
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_run_en", 32'(bus.run_en), 32'd1);
        check("mid_rst_set_load", 32'(bus.set_load), 32'd0);
        check("mid_rst_blink", 32'(bus.blink_mask), 32'd0);
        check("mid_rst_disp", 32'(bus.disp_time), 32'd0);
        sync();
        press(0, 1, 0);
        @(negedge clk);
        check("run_ignores_inc", 32'(bus.run_en), 32'd1);
        check("run_disp_tracks", 32'(bus.disp_time), 32'(tp(10, 20, 30)));
        $display("txn: reset mid-edit");

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pending_loads", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
